// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default baud/stop constants,
// used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned UART_BR_LIMIT      = 326;
  localparam int unsigned UART_STOP_BIT_TICK = 16;
  localparam int unsigned UART_SAMPLE_TICKS  = 16;

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO, 2^ADDR_W entries, registered full/empty flags, head word
// visible on rd_data whenever not empty. Pushes while full are dropped.
module fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned   DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push, pop;

  always_comb begin
    push     = wr_en && !full_q;
    pop      = rd_en && !empty_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      if (push) mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit engine: baud tick generator, frame FSM and shift register.
// Even parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned STOP_BIT_TICK = UART_STOP_BIT_TICK,
  parameter int unsigned BR_LIMIT      = UART_BR_LIMIT,
  parameter int unsigned BR_BITS       = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int unsigned TICK_W = 8;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BR_BITS-1:0] BR_LAST     = BR_BITS'(BR_LIMIT - 1);
  localparam logic [TICK_W-1:0]  SAMPLE_LAST = TICK_W'(UART_SAMPLE_TICKS - 1);
  localparam logic [TICK_W-1:0]  STOP_LAST   = TICK_W'(STOP_BIT_TICK - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST    = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [BR_BITS-1:0]   baud_q, baud_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif
  logic                 baud_tick, bit_done, stop_done;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_rd_en = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    baud_tick = (baud_q == BR_LAST);
    bit_done  = baud_tick && (tick_cnt_q == SAMPLE_LAST);
    stop_done = baud_tick && (tick_cnt_q == STOP_LAST);

    if (state_q == ST_IDLE || baud_tick) baud_d = '0;
    else                                 baud_d = baud_q + 1'b1;
    if (state_q != ST_IDLE && baud_tick) tick_cnt_d = tick_cnt_q + 1'b1;

    // tx_d always carries the level of the state being entered, so tx is a
    // pure flop output aligned with the state change.
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          shift_d    = fifo_rd_data;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = 1'b0;
          state_d    = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^fifo_rd_data;
`endif
        end
      end
      ST_START: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          tx_d       = shift_q[0];
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          tx_d       = 1'b1;
          state_d    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (stop_done) begin
          tick_cnt_d = '0;
          tx_d       = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO of outbound bytes feeding the 8N1 TX engine
// (8E1 when UART_TX_PARITY_EN is defined).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned STOP_BIT_TICK = UART_STOP_BIT_TICK,
  parameter int unsigned BR_LIMIT      = UART_BR_LIMIT,
  parameter int unsigned BR_BITS       = 9,
  parameter int unsigned FIFO_EXP      = 4
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 fifo_full,
  output logic                 fifo_empty
);

  logic                 fifo_rd_en;
  logic [DATA_BITS-1:0] fifo_rd_data;

  fifo #(
    .DATA_W (DATA_BITS),
    .ADDR_W (FIFO_EXP)
  ) u_fifo (
    .clk     (clk_50MHz),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  uart_tx_core #(
    .DATA_BITS     (DATA_BITS),
    .STOP_BIT_TICK (STOP_BIT_TICK),
    .BR_LIMIT      (BR_LIMIT),
    .BR_BITS       (BR_BITS)
  ) u_core (
    .clk          (clk_50MHz),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter, the outbound counterpart of the UART receive path: bytes pushed by the host logic are queued in a FIFO and serialized on `tx` as 8N1 frames at the same baud rate as the receiver (16× oversampled tick, BR_LIMIT=326 at 50 MHz ≈ 9600 baud). It sits between on-board producers (keypad/GPS formatting logic) and the board's serial TX pin.

## Interface
- `DATA_BITS`, 8: data bits per frame and FIFO width.
- `STOP_BIT_TICK`, 16: sample ticks in the stop bit (16 = 1 stop bit, 32 = 2).
- `BR_LIMIT`, 326: clocks per sample tick.
- `BR_BITS`, 9: width of baud counter; must satisfy 2^BR_BITS > BR_LIMIT.
- `FIFO_EXP`, 4: FIFO depth = 2^FIFO_EXP entries.

Ports:
- `clk_50MHz`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  push `wr_data` into FIFO this cycle.
- `wr_data`  in  DATA_BITS  byte to transmit.
- `tx`  out  1  serial line, idle high.
- `tx_busy`  out  1  high while a frame is on the line.
- `fifo_full`  out  1  FIFO holds 2^FIFO_EXP entries.
- `fifo_empty`  out  1  FIFO holds 0 entries.

## Operation
- Reset (sampled on clock edge while `reset`=0): `tx`=1, `tx_busy`=0, `fifo_empty`=1, `fifo_full`=0, FIFO pointers cleared, FSM to IDLE, baud and bit counters 0. A reset mid-frame aborts it; `tx` returns high on that edge.
- FIFO push: `wr_en`=1 with `fifo_full`=0 stores `wr_data`. `wr_en` with `fifo_full`=1 is dropped, even if the FSM pops in the same cycle. Push and pop in the same cycle on a non-empty, non-full FIFO: count unchanged.
- Baud counter held at 0 in IDLE; in other states counts 0..BR_LIMIT-1, `tick` on BR_LIMIT-1. Every bit is exactly 16×BR_LIMIT clocks (stop: STOP_BIT_TICK×BR_LIMIT).
- FSM states:
  - IDLE: `tx`=1. If `fifo_empty`=0: pop head, load shift register, clear tick/bit counters, go START.
  - START: `tx`=0; after 16 ticks go DATA.
  - DATA: `tx`=shift[0] (LSB first); every 16 ticks shift right, bit count+1; after bit DATA_BITS-1 go PARITY (if enabled) else STOP.
  - PARITY: `tx`=even parity of the byte; after 16 ticks go STOP.
  - STOP: `tx`=1; after STOP_BIT_TICK ticks go IDLE.
- `tx` is registered (no glitches); `tx_busy` = (state ≠ IDLE).

## Timing
- Push in cycle n into empty FIFO: `fifo_empty` falls at n+1; pop and START entered at n+2; `tx` falls at edge n+2.
- Frame length: (1+DATA_BITS+1)×16×BR_LIMIT clocks plus stop extension (+16×BR_LIMIT with parity).
- Back-to-back: STOP→IDLE on final tick; next START one cycle later (1 clock idle-high gap).
- `fifo_full`/`fifo_empty` update on the edge after the push/pop.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state compiled in, even parity bit after data (8E1).
- Not defined: no PARITY state, 8N1 frames, parity logic absent.

## Structure
- Shared package `uart_pkg`: FSM state encodings (IDLE/START/DATA/PARITY/STOP), default BR_LIMIT and STOP_BIT_TICK constants, shared with the receive path.
- Reuse existing `fifo` module for buffering; natural sub-module `uart_tx_core` (baud counter + FSM + shift register).

## Test plan
- BR_LIMIT=4: push 0x55 → `tx` low 64 clocks, then bits 1,0,1,0,1,0,1,0 at 64 clocks each, high 64 clocks; `tx_busy` high 640 clocks.
- Push 17 bytes 0x00..0x10 in consecutive cycles with FSM active → 16 stored, `fifo_full`=1, 0x10 dropped, 16 frames emitted in order with 1-clock gaps.
- Push when full in same cycle as pop → pushed byte dropped; count decreases by one.
- Assert reset mid DATA of 0xA3 → `tx`=1 next edge, `tx_busy`=0, `fifo_empty`=1, no further frames.
- `UART_TX_PARITY_EN`, push 0x07 → parity bit 1; push 0x03 → parity bit 0; frame 11 bits.
- STOP_BIT_TICK=32, push 0xFF → stop high 128 clocks before next start.
